// File: rtl/reg_sequencer.sv
// rtl/reg_sequencer.sv - expands clear/load/shift requests into register selector codes
// Returns the register value with a one-cycle done pulse after each request.
module reg_sequencer #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             preload,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] q,
  output logic [4:0]       selector,
  output logic [WIDTH-1:0] A,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {IDLE, PRELOAD, SHIFT, CLR, LD, FINISH} state_t;

  localparam logic [4:0] SEL_HOLD   = 5'd0;
  localparam logic [4:0] SEL_LOAD   = 5'd1;
  localparam logic [4:0] SEL_SHIFTR = 5'd2;
  localparam logic [4:0] SEL_SHIFTL = 5'd3;
  localparam logic [4:0] SEL_CLEAR  = 5'd4;

  state_t           state;
  logic             shift_left;
  logic [WIDTH-1:0] data_lat;
  logic [CNT_W-1:0] cnt;

  // Outputs are registered alongside the state they belong to, so each code
  // is stable for the whole cycle, including the register's negedge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_left <= 1'b0;
      data_lat   <= '0;
      cnt        <= '0;
      selector   <= SEL_HOLD;
      A          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
    end else begin
      selector <= SEL_HOLD;
      A        <= '0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_left <= op[0];
            data_lat   <= data_in;
            cnt        <= count;
            busy       <= 1'b1;
            case (op)
              2'b00: begin
                state    <= CLR;
                selector <= SEL_CLEAR;
              end
              2'b01: begin
                state    <= LD;
                selector <= SEL_LOAD;
                A        <= data_in;
              end
              default: begin
                if (preload) begin
                  state    <= PRELOAD;
                  selector <= SEL_LOAD;
                  A        <= data_in;
                end else if (count != '0) begin
                  state    <= SHIFT;
                  selector <= op[0] ? SEL_SHIFTL : SEL_SHIFTR;
                end else begin
                  // Nothing to issue: report the register as it stands.
                  state  <= FINISH;
                  done   <= 1'b1;
                  result <= q;
                end
              end
            endcase
          end
        end
        CLR, LD: begin
          state  <= FINISH;
          done   <= 1'b1;
          result <= q;
        end
        PRELOAD: begin
          if (cnt != '0) begin
            state    <= SHIFT;
            selector <= shift_left ? SEL_SHIFTL : SEL_SHIFTR;
          end else begin
            state  <= FINISH;
            done   <= 1'b1;
            result <= q;
          end
        end
        SHIFT: begin
          // cnt counts the shift cycles still owed, including the current one.
          if (cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state  <= FINISH;
            done   <= 1'b1;
            result <= q;
          end else begin
            cnt      <= cnt - 1'b1;
            selector <= shift_left ? SEL_SHIFTL : SEL_SHIFTR;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_sequencer.md
# reg_sequencer

Command sequencer that drives the `selector`/`A` interface of the 5-bit `register` block and reads back its `out`. It accepts one high-level request at a time: clear, load, or an N-step shift with optional preload. It expands the request into a cycle-by-cycle stream of HOLD/LOAD/SHIFTR/SHIFTL/CLEAR codes, then returns the final register value with a one-cycle `done` pulse. It sits between the datapath control logic and each `register` instance.

## Interface
- `WIDTH`, 5: data width; must match the driven register.
- `CNT_W`, 3: width of the shift count; maximum count is 2^CNT_W−1.

- `clk` in 1: clock; all sequencer state changes on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request strobe; sampled only in IDLE.
- `op` in 2: 00 CLEAR, 01 LOAD, 10 SHIFT RIGHT, 11 SHIFT LEFT.
- `preload` in 1: for shift ops, issue LOAD of `data_in` before the first shift; ignored for CLEAR/LOAD.
- `data_in` in WIDTH: load operand.
- `count` in CNT_W: number of shift steps.
- `q` in WIDTH: connected to the register's `out`.
- `selector` out 5: connected to the register's `selector`; codes HOLD=0, LOAD=1, SHIFTR=2, SHIFTL=3, CLEAR=4; registered.
- `A` out WIDTH: connected to the register's `A`; registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in FINISH.
- `result` out WIDTH: copy of `q` at completion; held until the next completion.

## Operation
- **States:** IDLE, PRELOAD, SHIFT, CLR, LD, FINISH.
- **IDLE:** `selector`=HOLD. On `start`=1, latch `op`, `preload`, `data_in` and `count` into internal registers. Input changes while busy have no effect.
- **Request acceptance:** `start` while busy (including FINISH) is ignored; it is not queued.
- **Transitions out of IDLE on start:**
  - op 00 → CLR.
  - op 01 → LD.
  - op 1x with `preload`=1 → PRELOAD.
  - op 1x with `preload`=0 and count≠0 → SHIFT.
  - op 1x with `preload`=0 and count=0 → FINISH.
- **CLR:** `selector`=CLEAR for one cycle → FINISH.
- **LD / PRELOAD:** `selector`=LOAD, `A`=latched data for one cycle.
  - LD → FINISH.
  - PRELOAD → SHIFT if count≠0, else FINISH.
- **SHIFT:** `selector`=SHIFTR (op 10) or SHIFTL (op 11). An internal down-counter is loaded with `count`. Leave for FINISH after exactly `count` cycles in SHIFT.
- **FINISH:** `selector`=HOLD, `done`=1, `busy`=1 → IDLE next cycle.
- **Result capture:** `result` loads `q` on the posedge that enters FINISH.
  - The register acts on the negedge inside each command cycle, so `q` already reflects the last command at that edge.
  - Shift arithmetic is the register's logical shift: zero fill, bits shifted past the MSB/LSB are lost, no saturation.
- **`A` behaviour:** `A` = latched data only in LD/PRELOAD; 0 otherwise.
- **Reset (any time, including mid-sequence):** immediately forces IDLE, `selector`=HOLD, `A`=0, `busy`=0, `done`=0, `result`=0.
  - The register's contents are left as they were; a partially executed shift is not undone.
  - No `done` pulse for an aborted request.

## Timing
- Edge 0 is the posedge where `start` is accepted; cycle n is the cycle after edge n−1.
- Latency from accept to `done`:
  - CLEAR: 2 cycles.
  - LOAD: 2 cycles.
  - Shift without preload: count+1 cycles.
  - Shift with preload: count+2 cycles.
  - count=0 without preload: 1 cycle; `result` = current `q`, and no non-HOLD code is issued.
- `done` is high for exactly one cycle. `busy` is 0 on the following cycle, and a new `start` is accepted there. Back-to-back request spacing is the latency plus one cycle.
- `selector` and `A` change only on posedge (or on async reset). They are stable across the register's negedge sampling point.
- Maximum count (7 with the default `CNT_W`) produces 7 shift cycles; there is no wrap of the step counter.

## Test plan
- **Reset:** assert `rst` asynchronously between edges → same instant: `selector`=0, `A`=0, `busy`=0, `done`=0, `result`=0; outputs stay there while `rst`=1.
- **LOAD:** op=01, `data_in`=10110 → cycle 1: `selector`=1, `A`=10110; cycle 2: `done`=1, `result`=10110; cycle 3: `busy`=0.
- **Preloaded shift right:** op=10, `preload`=1, `data_in`=10110, count=2 → `selector` sequence 1,2,2,0; `done` in cycle 4; `result`=00101.
- **Shift left with truncation:** starting from `q`=00101, op=11, `preload`=0, count=3 → `selector` 3,3,3; `done` in cycle 4; `result`=01000. Follow with op=00 → `selector`=4 in cycle 1, `result`=00000.
- **Count zero and busy start:** op=10, `preload`=0, count=0 → `done` in cycle 1, `selector` stays 0, `result` = prior `q`. Pulse `start` during a 7-step shift → ignored; exactly 7 SHIFT codes are issued and one `done`.
- **Reset mid-shift:** assert `rst` during cycle 2 of a count-5 shift → `selector`=0 immediately, no `done`, register holds its partially shifted value. A subsequent LOAD of 00011 completes normally with `result`=00011.
